// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: branch funct3 codes,
// FSM state encoding and the taken/illegal decode helpers.
package bru_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMP_HI = 2'd1,
    ST_HOLD   = 2'd2
  } bru_state_t;

  // lt_sel is already the signed/unsigned result chosen by f3[1], so the
  // inverted forms (BNE/BGE/BGEU) are just an xor with f3[0].
  function automatic logic bru_taken(input logic [2:0] f3, input logic eq,
                                     input logic lt_sel);
    logic t;
    if (f3[2]) begin
      t = lt_sel ^ f3[0];
    end else if (f3[1]) begin
      t = 1'b0;
    end else begin
      t = eq ^ f3[0];
    end
    return t;
  endfunction

  function automatic logic bru_illegal(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/bru_cmp_core.sv
// Combinational equality / unsigned less-than over a W-bit slice.
module bru_cmp_core #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq,
  output logic         o_ltu
);

  assign o_eq  = (i_a == i_b);
  assign o_ltu = (i_a < i_b);

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolver: eq/lt/ltu, taken decision and pc+imm target
// behind a valid/ready handshake. SPLIT_CMP=1 compares low half then high
// half over two cycles. Optional counters enabled by macro BRU_STATS_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int SPLIT_CMP = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [PC_W-1:0] out_target,
  output logic            out_eq,
  output logic            out_lt,
  output logic            out_illegal
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]     stat_total,
  output logic [31:0]     stat_taken
`endif
);

  localparam int HW = XLEN / 2;

  bru_state_t      r_state, w_state_next;
  logic            r_eq, r_lt, r_taken, r_illegal;
  logic [PC_W-1:0] r_target;

  logic            w_in_ready, w_accept, w_res_load;
  logic            w_eq, w_ltu, w_slt;
  logic [2:0]      w_f3;

  assign w_in_ready = !flush && ((r_state == ST_IDLE) ||
                                 ((r_state == ST_HOLD) && out_ready));
  assign w_accept   = in_valid && w_in_ready;

  generate
    if (SPLIT_CMP != 0) begin : g_split
      logic            w_eq_lo, w_ltu_lo, w_eq_hi, w_ltu_hi;
      logic            r_eq_lo, r_ltu_lo;
      logic [XLEN-1:HW] r_rs1_hi, r_rs2_hi;
      logic [2:0]      r_funct3;

      bru_cmp_core #(.W(HW)) u_cmp_lo (
        .i_a(rs1[HW-1:0]), .i_b(rs2[HW-1:0]), .o_eq(w_eq_lo), .o_ltu(w_ltu_lo)
      );
      bru_cmp_core #(.W(XLEN - HW)) u_cmp_hi (
        .i_a(r_rs1_hi), .i_b(r_rs2_hi), .o_eq(w_eq_hi), .o_ltu(w_ltu_hi)
      );

      // Capture the low-half result and the high-half operands on accept.
      always_ff @(posedge clk) begin
        if (w_accept) begin
          r_eq_lo  <= w_eq_lo;
          r_ltu_lo <= w_ltu_lo;
          r_rs1_hi <= rs1[XLEN-1:HW];
          r_rs2_hi <= rs2[XLEN-1:HW];
          r_funct3 <= funct3;
        end
      end

      assign w_eq       = w_eq_hi && r_eq_lo;
      assign w_ltu      = w_ltu_hi || (w_eq_hi && r_ltu_lo);
      assign w_slt      = (r_rs1_hi[XLEN-1] != r_rs2_hi[XLEN-1]) ? r_rs1_hi[XLEN-1] : w_ltu;
      assign w_f3       = r_funct3;
      assign w_res_load = (r_state == ST_CMP_HI) && !flush;
    end else begin : g_single
      bru_cmp_core #(.W(XLEN)) u_cmp (
        .i_a(rs1), .i_b(rs2), .o_eq(w_eq), .o_ltu(w_ltu)
      );

      assign w_slt      = (rs1[XLEN-1] != rs2[XLEN-1]) ? rs1[XLEN-1] : w_ltu;
      assign w_f3       = funct3;
      assign w_res_load = w_accept;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: flush wins; HOLD either reloads or drains to IDLE.
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) w_state_next = (SPLIT_CMP != 0) ? ST_CMP_HI : ST_HOLD;
        end
        ST_CMP_HI: w_state_next = ST_HOLD;
        ST_HOLD: begin
          if (out_ready) begin
            if (w_accept) w_state_next = (SPLIT_CMP != 0) ? ST_CMP_HI : ST_HOLD;
            else          w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Result registers: target on accept, compare results when they resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_target  <= '0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept) r_target <= pc + imm;
      if (w_res_load) begin
        r_eq      <= w_eq;
        r_lt      <= w_f3[1] ? w_ltu : w_slt;
        r_taken   <= bru_taken(w_f3, w_eq, w_f3[1] ? w_ltu : w_slt);
        r_illegal <= bru_illegal(w_f3);
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = (r_state == ST_HOLD);
  assign out_taken   = r_taken;
  assign out_target  = r_target;
  assign out_eq      = r_eq;
  assign out_lt      = r_lt;
  assign out_illegal = r_illegal;

`ifdef BRU_STATS_EN
  logic [31:0] r_stat_total, r_stat_taken;

  // Saturating completion counters; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_total <= '0;
      r_stat_taken <= '0;
    end else if (out_valid && out_ready) begin
      if (r_stat_total != 32'hFFFF_FFFF) r_stat_total <= r_stat_total + 32'd1;
      if (r_taken && (r_stat_taken != 32'hFFFF_FFFF)) r_stat_taken <= r_stat_taken + 32'd1;
    end
  end

  assign stat_total = r_stat_total;
  assign stat_taken = r_stat_taken;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: one instance per compare mode, directed
// scenarios plus randomized operations checked against a reference model.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [1:0]  flush = '0, in_valid = '0, out_ready = '0;
  logic [1:0]  in_ready, out_valid, out_taken, out_eq, out_lt, out_illegal;
  logic [2:0]  funct3 [2];
  logic [31:0] rs1 [2], rs2 [2], pc [2], imm [2], out_target [2];
`ifdef BRU_STATS_EN
  logic [31:0] stat_total [2], stat_taken [2];
`endif

  int tests = 0;
  int fails = 0;

  branch_resolve_unit #(.XLEN(32), .PC_W(32), .SPLIT_CMP(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .funct3(funct3[0]), .rs1(rs1[0]), .rs2(rs2[0]), .pc(pc[0]), .imm(imm[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_taken(out_taken[0]),
    .out_target(out_target[0]), .out_eq(out_eq[0]), .out_lt(out_lt[0]),
    .out_illegal(out_illegal[0])
`ifdef BRU_STATS_EN
    , .stat_total(stat_total[0]), .stat_taken(stat_taken[0])
`endif
  );

  branch_resolve_unit #(.XLEN(32), .PC_W(32), .SPLIT_CMP(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .funct3(funct3[1]), .rs1(rs1[1]), .rs2(rs2[1]), .pc(pc[1]), .imm(imm[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_taken(out_taken[1]),
    .out_target(out_target[1]), .out_eq(out_eq[1]), .out_lt(out_lt[1]),
    .out_illegal(out_illegal[1])
`ifdef BRU_STATS_EN
    , .stat_total(stat_total[1]), .stat_taken(stat_taken[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: branch semantics straight from the ISA rules.
  task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic eq, output logic lt, output logic tk, output logic il);
    logic slt, ult;
    eq  = (a == b);
    slt = ($signed(a) < $signed(b));
    ult = (a < b);
    lt  = f3[1] ? ult : slt;
    il  = (f3 == 3'd2) || (f3 == 3'd3);
    case (f3)
      3'd0: tk = eq;
      3'd1: tk = !eq;
      3'd4: tk = slt;
      3'd5: tk = !slt;
      3'd6: tk = ult;
      3'd7: tk = !ult;
      default: tk = 1'b0;
    endcase
  endtask

  task automatic drive(input int d, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p, input logic [31:0] im);
    funct3[d] = f3; rs1[d] = a; rs2[d] = b; pc[d] = p; imm[d] = im;
  endtask

  // One full transaction from an idle unit; called at a negedge.
  task automatic run_op(input int d, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] p, input logic [31:0] im,
                        input string tag);
    logic e_eq, e_lt, e_tk, e_il;
    int lat;
    model(f3, a, b, e_eq, e_lt, e_tk, e_il);
    drive(d, f3, a, b, p, im);
    in_valid[d]  = 1'b1;
    out_ready[d] = 1'b0;
    #1;
    check({tag, ".in_ready"}, {31'd0, in_ready[d]}, 32'd1);
    @(negedge clk);
    in_valid[d] = 1'b0;
    lat = 1;
    while (out_valid[d] !== 1'b1 && lat < 8) begin
      if (d == 1) check({tag, ".rdy_cmphi"}, {31'd0, in_ready[d]}, 32'd0);
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, d + 1);
    check({tag, ".taken"},   {31'd0, out_taken[d]}, {31'd0, e_tk});
    check({tag, ".target"},  out_target[d], p + im);
    check({tag, ".eq"},      {31'd0, out_eq[d]}, {31'd0, e_eq});
    check({tag, ".lt"},      {31'd0, out_lt[d]}, {31'd0, e_lt});
    check({tag, ".illegal"}, {31'd0, out_illegal[d]}, {31'd0, e_il});
    $display("[TB] %s dut%0d f3=%0d a=%h b=%h lat=%0d taken=%b target=%h",
             tag, d, f3, a, b, lat, out_taken[d], out_target[d]);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check({tag, ".drain"}, {31'd0, out_valid[d]}, 32'd0);
  endtask

  task automatic check_reset_state(input int d, input string tag);
    check({tag, ".valid"},   {31'd0, out_valid[d]}, 32'd0);
    check({tag, ".taken"},   {31'd0, out_taken[d]}, 32'd0);
    check({tag, ".target"},  out_target[d], 32'd0);
    check({tag, ".eq"},      {31'd0, out_eq[d]}, 32'd0);
    check({tag, ".lt"},      {31'd0, out_lt[d]}, 32'd0);
    check({tag, ".illegal"}, {31'd0, out_illegal[d]}, 32'd0);
    check({tag, ".in_ready"}, {31'd0, in_ready[d]}, 32'd1);
  endtask

  initial begin : stim
    logic e_eq, e_lt, e_tk, e_il, b_eq, b_lt, b_tk, b_il;
    logic [31:0] a, b, t;
    logic [2:0] f3;
    for (int d = 0; d < 2; d++) drive(d, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state(0, "rst0");
    check_reset_state(1, "rst1");
    $display("[TB] reset state checked");
    @(negedge clk);

    // Directed: signed vs unsigned, wraparound target, split BGEU, illegal
    run_op(0, 3'b100, 32'h8000_0000, 32'h0000_0000, 32'h0000_0200, 32'h0000_0010, "blt_neg");
    run_op(0, 3'b110, 32'h8000_0000, 32'h0000_0000, 32'h0000_0200, 32'h0000_0010, "bltu_neg");
    run_op(0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0100, 32'hFFFF_FFF0, "beq_wrap");
    run_op(1, 3'b111, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_1000, 32'h0000_0008, "bgeu_split");
    run_op(1, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_1000, 32'h0000_0004, "blt_split");
    run_op(0, 3'b011, 32'h0000_0005, 32'h0000_0005, 32'h0000_0040, 32'h0000_0004, "illegal0");
    run_op(1, 3'b010, 32'h0000_0001, 32'h0000_0002, 32'h0000_0040, 32'h0000_0004, "illegal1");

    // Backpressure: five stalled cycles, then back-to-back accept
    model(3'b101, 32'h0000_0003, 32'hFFFF_FFFE, e_eq, e_lt, e_tk, e_il);
    drive(0, 3'b101, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_3000, 32'h0000_0020);
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp.valid",    {31'd0, out_valid[0]}, 32'd1);
      check("bp.in_ready", {31'd0, in_ready[0]}, 32'd0);
      check("bp.taken",    {31'd0, out_taken[0]}, {31'd0, e_tk});
      check("bp.target",   out_target[0], 32'h0000_3020);
      @(negedge clk);
    end
    model(3'b001, 32'h1234_5678, 32'h1234_5678, b_eq, b_lt, b_tk, b_il);
    drive(0, 3'b001, 32'h1234_5678, 32'h1234_5678, 32'h0000_4000, 32'hFFFF_FFFC);
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    #1;
    check("b2b.in_ready", {31'd0, in_ready[0]}, 32'd1);
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    check("b2b.valid",  {31'd0, out_valid[0]}, 32'd1);
    check("b2b.taken",  {31'd0, out_taken[0]}, {31'd0, b_tk});
    check("b2b.eq",     {31'd0, out_eq[0]}, {31'd0, b_eq});
    check("b2b.target", out_target[0], 32'h0000_3FFC);
    $display("[TB] backpressure + back-to-back done taken=%b target=%h", out_taken[0], out_target[0]);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;

    // Flush while in CMP_HI with a new offer pending
    drive(1, 3'b000, 32'h0000_0007, 32'h0000_0007, 32'h0000_5000, 32'h0000_0004);
    in_valid[1] = 1'b1;
    @(negedge clk);
    flush[1] = 1'b1;
    drive(1, 3'b001, 32'h0000_0001, 32'h0000_0002, 32'h0000_6000, 32'h0000_0004);
    #1;
    check("flush.in_ready", {31'd0, in_ready[1]}, 32'd0);
    @(negedge clk);
    flush[1]    = 1'b0;
    in_valid[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("flush.valid", {31'd0, out_valid[1]}, 32'd0);
      @(negedge clk);
    end
    check("flush.idle", {31'd0, in_ready[1]}, 32'd1);
    $display("[TB] flush in CMP_HI dropped operation");
    run_op(1, 3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_7000, 32'h0000_0100, "post_flush");

    // Reset in the middle of a split operation
    drive(1, 3'b000, 32'h0000_0009, 32'h0000_0009, 32'h0000_8000, 32'h0000_0004);
    in_valid[1] = 1'b1;
    @(negedge clk);
    in_valid[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state(1, "midrst");
    @(negedge clk);
    @(negedge clk);
    check("midrst.later", {31'd0, out_valid[1]}, 32'd0);
    $display("[TB] reset mid-operation gave no result");

    // Randomized operations on both modes
    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < 2; d++) begin
        a  = $urandom;
        t  = $urandom;
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0: b = a;
          1: b = a ^ 32'h8000_0000;
          2: b = {a[31:16], t[15:0]};
          default: b = t;
        endcase
        run_op(d, f3, a, b, $urandom, $urandom, "rand");
      end
    end

`ifdef BRU_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("stat.rst_total", stat_total[0], 32'd0);
    check("stat.rst_taken", stat_taken[0], 32'd0);
    @(negedge clk);
    run_op(0, 3'b000, 32'd4, 32'd4, 32'd0, 32'd4, "st_beq");
    run_op(0, 3'b001, 32'd4, 32'd4, 32'd0, 32'd4, "st_bne");
    run_op(0, 3'b100, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd4, "st_blt");
    run_op(0, 3'b111, 32'd0, 32'd1, 32'd0, 32'd4, "st_bgeu");
    run_op(0, 3'b110, 32'd1, 32'd2, 32'd0, 32'd4, "st_bltu");
    check("stat.total", stat_total[0], 32'd5);
    check("stat.taken", stat_taken[0], 32'd3);
    check("stat.other", stat_total[1], 32'd0);
    $display("[TB] stats total=%0d taken=%0d", stat_total[0], stat_taken[0]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("stat.clr_total", stat_total[0], 32'd0);
    check("stat.clr_taken", stat_taken[0], 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, registered successor to the combinational branch comparator. Accepts one branch operation per handshake and resolves eq/lt/ltu, the taken decision and the target PC for all six RV32/RV64 branch funct3 encodings.
- Sits between the execute-stage operand mux and the PC-select logic.
- Optional split compare spreads the compare over two cycles for timing at wide XLEN.
- Signed compare is true two's complement: 0x80000000 is the most negative value, and there is no negative zero.

Parameters:
- XLEN, 32, operand width; must be even, >= 8.
- PC_W, 32, PC/target width; the imm input is also PC_W wide.
- SPLIT_CMP, 0, 0 = single-cycle compare (latency 1); 1 = two-cycle compare, low half then high half (latency 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous kill of any in-flight or held operation.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- funct3  in  3  branch encoding.
- rs1  in  XLEN  operand A.
- rs2  in  XLEN  operand B.
- pc  in  PC_W  branch PC.
- imm  in  PC_W  sign-extended offset.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_taken  out  1  branch taken.
- out_target  out  PC_W  pc+imm.
- out_eq  out  1  rs1==rs2.
- out_lt  out  1  compare result selected by funct3[1]: signed lt when 0, unsigned lt when 1.
- out_illegal  out  1  funct3 is 010 or 011.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE; all out_* = 0.
- FSM states: IDLE, CMP_HI (only when SPLIT_CMP=1), HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready).
- Accept condition: in_valid && in_ready. On accept, latch funct3, rs1, rs2, pc and imm.
- SPLIT_CMP=0:
  - Accept -> HOLD; results registered on the same edge.
  - Latency 1; back-to-back throughput is 1 per cycle when out_ready=1.
- SPLIT_CMP=1:
  - Accept -> CMP_HI. Register eq_lo and ltu_lo, computed over bits [XLEN/2-1:0].
  - Next cycle, combine with the high half:
    - eq = eq_hi && eq_lo.
    - ltu = ltu_hi || (eq_hi && ltu_lo).
    - lt = (sign bits differ) ? rs1[XLEN-1] : ltu.
  - Then -> HOLD. Latency 2; throughput is 1 per 2 cycles. in_ready=0 in CMP_HI.
- HOLD: out_valid=1. Outputs are stable until out_ready=1.
  - out_ready=1 and a new accept in the same cycle -> load the new operation (CMP_HI or HOLD).
  - out_ready=1 with no accept -> IDLE; out_valid drops to 0.
- Taken decode by funct3:
  - 000 eq; 001 !eq.
  - 100 lt; 101 !lt.
  - 110 ltu; 111 !ltu.
  - 010/011: out_taken=0, out_illegal=1, with eq/lt still reported.
- Target arithmetic: out_target = pc + imm, modulo 2^PC_W, no overflow flag. Computed on accept in both modes.
- flush: priority over everything except rst.
  - Next state IDLE; out_valid=0.
  - An accept in the flush cycle is dropped, and in_ready=0 in that cycle.
  - Data outputs may retain stale values; consumers qualify them with out_valid.
- rst mid-operation: identical to reset; no partial result emerges.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined: adds ports stat_total (out, 32) and stat_taken (out, 32).
  - stat_total increments on every completed handshake (out_valid && out_ready), including illegal operations.
  - stat_taken increments when that completed operation has out_taken=1.
  - Both saturate at 0xFFFFFFFF.
  - Cleared by rst only; flush does not clear them.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package bru_pkg holds:
  - funct3 localparams (F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU).
  - FSM state encoding.
- Sub-module bru_cmp_core: combinational eq/ltu over a parametrised width. Instanced once for the full width (SPLIT_CMP=0), or twice for the low and high halves (SPLIT_CMP=1).

Test Plan:
1. SPLIT_CMP=0, BLT:
   - rs1=0x80000000, rs2=0x00000000 -> eq=0, lt=1, taken=1.
   - BLTU on the same operands -> taken=0.
2. BEQ, rs1=rs2=0xFFFFFFFF, pc=0x100, imm=0xFFFFFFF0 -> one cycle later: out_valid=1, taken=1, target=0x000000F0.
3. SPLIT_CMP=1, BGEU, rs1=0x00010000, rs2=0x0000FFFF -> out_valid exactly 2 cycles after accept; taken=1; in_ready=0 during CMP_HI.
4. Backpressure:
   - Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0.
   - Then out_ready=1 with in_valid=1: back-to-back accept, next result 1 cycle later.
5. flush asserted in CMP_HI with in_valid=1 -> next cycle out_valid=0, state IDLE, no result emitted.
6. funct3=011 -> illegal=1, taken=0. With BRU_STATS_EN: after 3 taken and 2 not-taken completions, stat_total=5, stat_taken=3; rst clears both to 0.
